wb_retire_queue: RTL and testbench

- Write-back/retire block. Accepts completed results from the MEM stage and buffers them in order in a small FIFO.
- Drains one result per cycle onto the from_WB_to_DE register/CSR write bus, which the DE stage uses for its regfile write and busy-bit release.
- Provides a combinational forwarding lookup over pending results and counts retired instructions.

---
 rtl/wb_retire_queue_pkg.sv | 36 +++
 rtl/wb_retire_queue_if.sv | 39 +++
 rtl/wb_retire_queue_fifo.sv | 70 +++++++
 rtl/wb_retire_queue.sv | 170 +++++++++++++++++
 tb/tb_wb_retire_queue.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_retire_queue_pkg.sv
// Shared types and widths for the write-back retire queue.
// Default widths match the DE-side register/CSR write bus.
package wb_pkg;

  localparam int WB_DBITS     = 32;
  localparam int WB_REGNOBITS = 5;
  localparam int WB_CSRNOBITS = 4;
  localparam int WB_DEPTH     = 4;

  typedef struct packed {
    logic                    wr_reg;
    logic [WB_REGNOBITS-1:0] wregno;
    logic [WB_DBITS-1:0]     regval;
    logic                    wr_csr;
    logic [WB_CSRNOBITS-1:0] wcsrno;
  } wb_entry_t;

  localparam int WB_ENTRY_WIDTH = $bits(wb_entry_t);
  localparam int WB_TO_DE_WIDTH = WB_ENTRY_WIDTH;

  // Field order must track the unpack on the DE side.
  function automatic logic [WB_TO_DE_WIDTH-1:0] pack_wb_to_de(
    input wb_entry_t e
  );
    return {e.wr_reg, e.wregno, e.regval, e.wcsrno, e.wr_csr};
  endfunction

  function automatic wb_entry_t unpack_wb_to_de(
    input logic [WB_TO_DE_WIDTH-1:0] v
  );
    wb_entry_t e;
    {e.wr_reg, e.wregno, e.regval, e.wcsrno, e.wr_csr} = v;
    return e;
  endfunction

endpackage

// File: rtl/wb_retire_queue_if.sv
// MEM-to-WB completion handshake.
// MEM is the master; the retire queue is the slave.
interface wb_retire_queue_if
  import wb_pkg::*;
#(
  parameter int DBITS     = WB_DBITS,
  parameter int REGNOBITS = WB_REGNOBITS,
  parameter int CSRNOBITS = WB_CSRNOBITS
);

  logic                 mem_valid;
  logic                 mem_ready;
  logic                 mem_wr_reg;
  logic [REGNOBITS-1:0] mem_wregno;
  logic                 mem_wr_csr;
  logic [CSRNOBITS-1:0] mem_wcsrno;
  logic [DBITS-1:0]     mem_regval;

  modport master (
    output mem_valid,
    output mem_wr_reg,
    output mem_wregno,
    output mem_wr_csr,
    output mem_wcsrno,
    output mem_regval,
    input  mem_ready
  );

  modport slave (
    input  mem_valid,
    input  mem_wr_reg,
    input  mem_wregno,
    input  mem_wr_csr,
    input  mem_wcsrno,
    input  mem_regval,
    output mem_ready
  );

endinterface

// File: rtl/wb_retire_queue_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers.
// Entry storage and valids are exposed for lookups.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic [$clog2(DEPTH)-1:0]     o_rptr,
  output logic [DEPTH-1:0]             o_vld,
  output logic [DEPTH-1:0][WIDTH-1:0]  o_mem
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                r_wptr;
  logic [AW:0]                r_rptr;
  logic [DEPTH-1:0]           r_vld;
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;

  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_widx;
  logic [AW-1:0] w_ridx;

  assign w_widx  = r_wptr[AW-1:0];
  assign w_ridx  = r_rptr[AW-1:0];
  assign o_count = r_wptr - r_rptr;
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign o_empty = (o_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  assign o_rdata = r_mem[w_ridx];
  assign o_rptr  = w_ridx;
  assign o_vld   = r_vld;
  assign o_mem   = r_mem;

  // Push and pop never target one slot: that needs empty or full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_vld  <= '0;
    end else begin
      if (w_push) begin
        r_wptr         <= r_wptr + (AW+1)'(1);
        r_vld[w_widx]  <= 1'b1;
      end
      if (w_pop) begin
        r_rptr         <= r_rptr + (AW+1)'(1);
        r_vld[w_ridx]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_widx] <= i_wdata;
    end
  end

endmodule

// File: rtl/wb_retire_queue.sv
// Write-back retire queue: in-order buffer from MEM, one
// retire per cycle to DE, with pending-result forwarding.
module wb_retire_queue
  import wb_pkg::*;
#(
  parameter int DBITS     = WB_DBITS,
  parameter int REGNOBITS = WB_REGNOBITS,
  parameter int CSRNOBITS = WB_CSRNOBITS,
  parameter int DEPTH     = WB_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_retire_queue_if.slave     mem,
  input  logic                 wb_en,
  output logic                 wr_reg_WB,
  output logic [REGNOBITS-1:0] wregno_WB,
  output logic [DBITS-1:0]     regval_WB,
  output logic [CSRNOBITS-1:0] wcsrno_WB,
  output logic                 wr_csr_WB,
  input  logic [REGNOBITS-1:0] fwd_rs1,
  output logic                 fwd_rs1_hit,
  output logic [DBITS-1:0]     fwd_rs1_val,
  input  logic [REGNOBITS-1:0] fwd_rs2,
  output logic                 fwd_rs2_hit,
  output logic [DBITS-1:0]     fwd_rs2_val,
  output logic [31:0]          retired_count,
  output logic                 proto_err
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic                 wr_reg;
    logic [REGNOBITS-1:0] wregno;
    logic [DBITS-1:0]     regval;
    logic                 wr_csr;
    logic [CSRNOBITS-1:0] wcsrno;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t                   w_in;
  entry_t                   w_head;
  entry_t [DEPTH-1:0]       w_ent;
  logic [DEPTH-1:0][EW-1:0] w_mem;
  logic [EW-1:0]            w_rdata;
  logic                     w_full;
  logic                     w_empty;
  logic [AW:0]              w_count;
  logic [AW-1:0]            w_rptr;
  logic [DEPTH-1:0]         w_vld;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_both;

  logic                 r_wr_reg;
  logic [REGNOBITS-1:0] r_wregno;
  logic [DBITS-1:0]     r_regval;
  logic [CSRNOBITS-1:0] r_wcsrno;
  logic                 r_wr_csr;
  logic [31:0]          r_retired;
  logic                 r_perr;

  assign mem.mem_ready = (w_count != (AW+1)'(DEPTH));

  assign w_push = mem.mem_valid && !w_full;
  assign w_pop  = wb_en && !w_empty;
  assign w_both = mem.mem_wr_reg && mem.mem_wr_csr;

  // x0 writes are dropped; a double-flag write keeps the GPR side.
  always_comb begin
    w_in        = '0;
    w_in.wr_reg = mem.mem_wr_reg && (mem.mem_wregno != '0);
    w_in.wregno = mem.mem_wregno;
    w_in.regval = mem.mem_regval;
    w_in.wr_csr = mem.mem_wr_csr && !mem.mem_wr_reg;
    w_in.wcsrno = mem.mem_wcsrno;
  end

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_wdata (w_in),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_rptr  (w_rptr),
    .o_vld   (w_vld),
    .o_mem   (w_mem)
  );

  assign w_head = w_rdata;
  assign w_ent  = w_mem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_reg  <= 1'b0;
      r_wregno  <= '0;
      r_regval  <= '0;
      r_wcsrno  <= '0;
      r_wr_csr  <= 1'b0;
      r_retired <= '0;
      r_perr    <= 1'b0;
    end else begin
      r_wr_reg <= 1'b0;
      r_wr_csr <= 1'b0;
      if (w_pop) begin
        r_wr_reg  <= w_head.wr_reg;
        r_wregno  <= w_head.wregno;
        r_regval  <= w_head.regval;
        r_wcsrno  <= w_head.wcsrno;
        r_wr_csr  <= w_head.wr_csr;
        r_retired <= r_retired + 32'd1;
      end
      if (w_push && w_both) begin
        r_perr <= 1'b1;
      end
    end
  end

  assign wr_reg_WB     = r_wr_reg;
  assign wregno_WB     = r_wregno;
  assign regval_WB     = r_regval;
  assign wcsrno_WB     = r_wcsrno;
  assign wr_csr_WB     = r_wr_csr;
  assign retired_count = r_retired;
  assign proto_err     = r_perr;

  // Scan oldest to youngest so the last match is the youngest.
  function automatic logic [DBITS:0] fwd_lookup(
    input logic [REGNOBITS-1:0] rs,
    input logic [DEPTH-1:0]     vld,
    input entry_t [DEPTH-1:0]   ent,
    input logic [AW-1:0]        rptr,
    input logic                 out_en,
    input logic [REGNOBITS-1:0] out_no,
    input logic [DBITS-1:0]     out_val
  );
    logic [DBITS:0] res;
    logic [AW-1:0]  idx;
    res = '0;
    if (out_en && out_no == rs) begin
      res = {1'b1, out_val};
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr + AW'(k);
      if (vld[idx] && ent[idx].wr_reg && ent[idx].wregno == rs) begin
        res = {1'b1, ent[idx].regval};
      end
    end
    if (rs == '0) begin
      res = '0;
    end
    return res;
  endfunction

  always_comb begin
    {fwd_rs1_hit, fwd_rs1_val} = fwd_lookup(
      fwd_rs1, w_vld, w_ent, w_rptr, r_wr_reg, r_wregno, r_regval);
    {fwd_rs2_hit, fwd_rs2_val} = fwd_lookup(
      fwd_rs2, w_vld, w_ent, w_rptr, r_wr_reg, r_wregno, r_regval);
  end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed bench for wb_retire_queue: vector table
// plus sequences for forwarding, backpressure and reset.
module tb_wb_retire_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic        wr_reg_WB;
  logic [4:0]  wregno_WB;
  logic [31:0] regval_WB;
  logic [3:0]  wcsrno_WB;
  logic        wr_csr_WB;
  logic [4:0]  fwd_rs1;
  logic        fwd_rs1_hit;
  logic [31:0] fwd_rs1_val;
  logic [4:0]  fwd_rs2;
  logic        fwd_rs2_hit;
  logic [31:0] fwd_rs2_val;
  logic [31:0] retired_count;
  logic        proto_err;

  int n_chk = 0;
  int n_err = 0;

  wb_retire_queue_if mif ();

  wb_retire_queue dut (
    .clk           (clk),
    .reset         (rst_n),
    .mem           (mif),
    .wb_en         (wb_en),
    .wr_reg_WB     (wr_reg_WB),
    .wregno_WB     (wregno_WB),
    .regval_WB     (regval_WB),
    .wcsrno_WB     (wcsrno_WB),
    .wr_csr_WB     (wr_csr_WB),
    .fwd_rs1       (fwd_rs1),
    .fwd_rs1_hit   (fwd_rs1_hit),
    .fwd_rs1_val   (fwd_rs1_val),
    .fwd_rs2       (fwd_rs2),
    .fwd_rs2_hit   (fwd_rs2_hit),
    .fwd_rs2_val   (fwd_rs2_val),
    .retired_count (retired_count),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_reg;
    logic [4:0]  wregno;
    logic        wr_csr;
    logic [3:0]  wcsrno;
    logic [31:0] regval;
    logic        e_wr_reg;
    logic        e_wr_csr;
    logic        e_perr;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [4:0] rn,
                       input logic wc, input logic [3:0] cn,
                       input logic [31:0] v);
    mif.mem_wr_reg = wr;
    mif.mem_wregno = rn;
    mif.mem_wr_csr = wc;
    mif.mem_wcsrno = cn;
    mif.mem_regval = v;
  endtask

  task automatic enq(input logic wr, input logic [4:0] rn,
                     input logic [31:0] v);
    drive(wr, rn, 1'b0, 4'd0, v);
    mif.mem_valid = 1'b1;
    tick();
    mif.mem_valid = 1'b0;
  endtask

  task automatic pop1();
    wb_en = 1'b1;
    tick();
    wb_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 5'd7,  1'b0, 4'd1,  32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 5'd0,  1'b0, 4'd2,  32'h00001234, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 5'd4,  1'b1, 4'd3,  32'h00000040, 1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b0, 5'd5,  1'b0, 4'd6,  32'h00000055, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 5'd9,  1'b1, 4'd2,  32'h00000099, 1'b1, 1'b0, 1'b1};
    vt[5] = '{1'b1, 5'd31, 1'b0, 4'd15, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b1;
    wb_en = 1'b0;
    fwd_rs1 = '0;
    fwd_rs2 = '0;
    mif.mem_valid = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 4'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst wr_reg_WB", 32'(wr_reg_WB), 32'd0);
    chk("rst wr_csr_WB", 32'(wr_csr_WB), 32'd0);
    chk("rst regval_WB", regval_WB, 32'd0);
    chk("rst retired", retired_count, 32'd0);
    chk("rst proto_err", 32'(proto_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst mem_ready", 32'(mif.mem_ready), 32'd1);
    tick();

    for (int i = 0; i < 6; i++) begin
      drive(vt[i].wr_reg, vt[i].wregno, vt[i].wr_csr,
            vt[i].wcsrno, vt[i].regval);
      mif.mem_valid = 1'b1;
      wb_en = 1'b1;
      #1;
      chk($sformatf("v%0d mem_ready", i), 32'(mif.mem_ready), 32'd1);
      tick();
      mif.mem_valid = 1'b0;
      chk($sformatf("v%0d no_bypass", i),
          32'(wr_reg_WB | wr_csr_WB), 32'd0);
      tick();
      chk($sformatf("v%0d wr_reg_WB", i), 32'(wr_reg_WB),
          32'(vt[i].e_wr_reg));
      chk($sformatf("v%0d wregno_WB", i), 32'(wregno_WB),
          32'(vt[i].wregno));
      chk($sformatf("v%0d regval_WB", i), regval_WB, vt[i].regval);
      chk($sformatf("v%0d wr_csr_WB", i), 32'(wr_csr_WB),
          32'(vt[i].e_wr_csr));
      chk($sformatf("v%0d wcsrno_WB", i), 32'(wcsrno_WB),
          32'(vt[i].wcsrno));
      chk($sformatf("v%0d proto_err", i), 32'(proto_err),
          32'(vt[i].e_perr));
      chk($sformatf("v%0d retired", i), retired_count, 32'(i + 1));
      tick();
      chk($sformatf("v%0d pulse_end", i),
          32'(wr_reg_WB | wr_csr_WB), 32'd0);
      chk($sformatf("v%0d regval_hold", i), regval_WB, vt[i].regval);
    end
    wb_en = 1'b0;

    enq(1'b1, 5'd5, 32'h11);
    enq(1'b1, 5'd5, 32'h22);
    enq(1'b0, 5'd5, 32'h33);
    fwd_rs1 = 5'd5;
    fwd_rs2 = 5'd0;
    #1;
    chk("fwd rs1 hit", 32'(fwd_rs1_hit), 32'd1);
    chk("fwd rs1 val", fwd_rs1_val, 32'h22);
    chk("fwd rs2=0 hit", 32'(fwd_rs2_hit), 32'd0);
    chk("fwd rs2=0 val", fwd_rs2_val, 32'd0);
    fwd_rs2 = 5'd7;
    #1;
    chk("fwd rs2 miss", 32'(fwd_rs2_hit), 32'd0);
    pop1();
    chk("fwd drain0 val", regval_WB, 32'h11);
    chk("fwd q over out", fwd_rs1_val, 32'h22);
    pop1();
    chk("fwd outreg hit", 32'(fwd_rs1_hit), 32'd1);
    chk("fwd outreg val", fwd_rs1_val, 32'h22);
    tick();
    chk("fwd store ign hit", 32'(fwd_rs1_hit), 32'd0);
    chk("fwd store ign val", fwd_rs1_val, 32'd0);
    pop1();
    chk("fwd store wr_reg", 32'(wr_reg_WB), 32'd0);
    chk("fwd store val", regval_WB, 32'h33);
    chk("fwd retired", retired_count, 32'd9);

    for (int k = 1; k <= 4; k++) begin
      enq(1'b1, 5'(k), 32'hA0 + 32'(k));
    end
    chk("full mem_ready", 32'(mif.mem_ready), 32'd0);
    drive(1'b1, 5'd6, 1'b0, 4'd0, 32'hA5);
    mif.mem_valid = 1'b1;
    wb_en = 1'b1;
    #1;
    chk("full offer ready", 32'(mif.mem_ready), 32'd0);
    tick();
    mif.mem_valid = 1'b0;
    chk("full drain1 val", regval_WB, 32'hA1);
    chk("full drain1 no", 32'(wregno_WB), 32'd1);
    chk("full ready rise", 32'(mif.mem_ready), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk($sformatf("full drain%0d val", k), regval_WB, 32'hA0 + 32'(k));
      chk($sformatf("full drain%0d wr", k), 32'(wr_reg_WB), 32'd1);
    end
    tick();
    chk("full no 5th wr", 32'(wr_reg_WB), 32'd0);
    chk("full no 5th val", regval_WB, 32'hA4);
    chk("full retired", retired_count, 32'd13);
    wb_en = 1'b0;

    enq(1'b1, 5'd8, 32'h81);
    enq(1'b1, 5'd9, 32'h91);
    enq(1'b1, 5'd10, 32'hA1);
    pop1();
    fwd_rs1 = 5'd9;
    #1;
    chk("mid pre hit", 32'(fwd_rs1_hit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid wr_reg_WB", 32'(wr_reg_WB), 32'd0);
    chk("mid wregno_WB", 32'(wregno_WB), 32'd0);
    chk("mid regval_WB", regval_WB, 32'd0);
    chk("mid retired", retired_count, 32'd0);
    chk("mid proto_err", 32'(proto_err), 32'd0);
    chk("mid fwd hit", 32'(fwd_rs1_hit), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("mid mem_ready", 32'(mif.mem_ready), 32'd1);
    wb_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mid stale%0d", k), 32'(wr_reg_WB), 32'd0);
      chk($sformatf("mid stale_cnt%0d", k), retired_count, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
